config_loader: RTL and testbench
================================

# config_loader

Bitstream loader that drives the fabric configuration shift chain from its input end. Accepts configuration words over a valid/ready stream, clears the fabric with a `config_nreset` pulse, then serialises exactly `CHAIN_BITS` bits LSB-first onto the chain's `config_in`, qualified by `config_enable`. While loading, it monitors the chain's far-end `config_out`, which must read all-zero after the clear, to flag chain integrity faults. Sits between the SoC-side bitstream source and the column array.

## Interface
- `CHAIN_BITS`, 1024: total configuration bits in the chain (≥1).
- `WORD_WIDTH`, 8: input word width (≥2).
- `CLEAR_CYCLES`, 4: cycles `cfg_nreset` is held low (≥1).

- `clock` in 1: single clock, all logic rising-edge.
- `nreset` in 1: reset, synchronous, active-low.
- `start` in 1: begin a load; sampled only in IDLE.
- `word_data` in WORD_WIDTH: bitstream word, bit 0 shifted first.
- `word_valid` in 1: `word_data` valid.
- `word_ready` out 1: loader accepts a word this cycle.
- `cfg_nreset` out 1: to fabric `config_nreset`.
- `cfg_enable` out 1: to fabric `config_enable`.
- `cfg_data` out 1: to first tile `config_in`.
- `cfg_return` in 1: from last tile `config_out`.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse at load completion.
- `error` out 1: sticky chain fault flag.

## Operation
- Reset values (while `nreset`=0 at an edge): state IDLE, `cfg_nreset`=1, `cfg_enable`=0, `cfg_data`=0, `word_ready`=0, `busy`=0, `done`=0, `error`=0, counters 0.
- IDLE: on `start`=1, go to CLEAR, clear `error` and the bit counter.
- CLEAR: `cfg_nreset`=0 for exactly CLEAR_CYCLES cycles, then go to FETCH.
- FETCH: `word_ready`=1. On `word_valid`&`word_ready`, load the shift register and go to SHIFT. `word_valid` low means wait indefinitely.
- SHIFT: each cycle `cfg_enable`=1 and `cfg_data`=shift_reg[0]. Shift right and increment the bit counter.
  - After WORD_WIDTH bits, go back to FETCH.
  - When the bit counter reaches CHAIN_BITS, go to DONE immediately, even mid-word. Unsent upper bits of the final word are discarded.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Integrity check: on every cycle with `cfg_enable`=1, `cfg_return`=1 sets `error`. `error` holds until the next accepted `start` or `nreset`.
- `start` is ignored outside IDLE. `word_valid` is ignored outside FETCH.
- `nreset` asserted mid-load aborts immediately to reset values. The fabric holds a partial config; the caller must restart.

## Timing
- All outputs are registered and change only on rising edges.
- Chain contract: a tile samples `cfg_data` on the edge ending a cycle in which `cfg_enable`=1. `cfg_return` is checked in that same cycle.
- Start accepted at edge 0:
  - `cfg_nreset` is low in cycles 1..CLEAR_CYCLES.
  - `word_ready` first goes high in cycle CLEAR_CYCLES+1.
- A handshake in cycle t gives `cfg_enable` high in cycles t+1..t+WORD_WIDTH. FETCH re-asserts `word_ready` in cycle t+WORD_WIDTH+1.
- Throughput is WORD_WIDTH+1 cycles per word, with a 1-cycle bubble per word.
- With N=ceil(CHAIN_BITS/WORD_WIDTH) and zero-wait source:
  - `done` occurs in cycle CLEAR_CYCLES + N + CHAIN_BITS + 1.
  - `busy` drops the following cycle.
- Bit counter width is $clog2(CHAIN_BITS+1). In-word counter width is $clog2(WORD_WIDTH+1). There is no wrap; the terminal compare is exact equality.

## Structure
- Shared package/header `config_pkg`:
  - state encoding localparams IDLE, CLEAR, FETCH, SHIFT, DONE.
  - chain-length constant used by both the column top and this loader.
- One natural sub-module: `config_serializer`, a PISO shift register with load/shift enables and the in-word counter. The FSM, bit counter, and error logic live in `config_loader`.

## Test plan
- Reset/idle: hold `nreset`=0 for 3 cycles, release -> all outputs at reset values. `word_valid`=1 with no `start` -> `word_ready` stays 0.
- Exact multiple (CHAIN_BITS=16, WORD_WIDTH=8, CLEAR_CYCLES=4), words 0xA5, 0x3C, zero-wait:
  - `cfg_nreset` low in cycles 1–4.
  - `cfg_data` sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - `done` in cycle 23.
- Partial last word (CHAIN_BITS=20), words 0xFF, 0x00, 0xFF:
  - exactly 20 enabled cycles.
  - last 4 bits all 1.
  - 3 handshakes, no 4th `word_ready`.
- Backpressure: source withholds `word_valid` 10 cycles between words -> `cfg_enable` stays 0 during the gap, and the bit stream is identical to the zero-wait case.
- Integrity fault: force `cfg_return`=1 on the 5th enabled cycle -> `error`=1 from the next cycle, through `done`. The next `start` clears it.
- Abort: `nreset`=0 during SHIFT of word 2 -> next cycle at reset values. `start` afterwards performs a full clean load with `done` timing as in scenario 2.

Source files
------------

// File: rtl/config_pkg.sv
// config_pkg: loader FSM states and the chain length shared by the column top and the loader.
package config_pkg;
   localparam int CHAIN_LEN = 1024;
   typedef enum logic [2:0] {IDLE, CLEAR, FETCH, SHIFT, DONE} state_t;
endpackage

// File: rtl/config_serializer.sv
// config_serializer: LSB-first PISO shift register with an in-word bit counter.
module config_serializer #(
   parameter int WORD_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  logic                  i_load,
   input  logic                  i_shift,
   input  logic                  i_clear,
   input  logic [WORD_WIDTH-1:0] i_data,
   output logic                  o_bit,
   output logic                  o_last
);
   localparam int CW = $clog2(WORD_WIDTH + 1);
   logic [WORD_WIDTH-1:0] r_sr;
   logic [CW-1:0]         r_cnt;
   // Zero fill keeps the chain input low once a word has been fully sent.
   always_ff @(posedge clock) begin
      if (!nreset || i_clear) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_sr  <= i_data;
         r_cnt <= '0;
      end else if (i_shift) begin
         r_sr  <= {1'b0, r_sr[WORD_WIDTH-1:1]};
         r_cnt <= r_cnt + 1'b1;
      end
   end
   assign o_bit  = r_sr[0];
   assign o_last = r_cnt == CW'(WORD_WIDTH - 1);
endmodule

// File: rtl/config_loader.sv
// config_loader: clears the fabric, then streams CHAIN_BITS configuration bits into the shift chain
// while watching the chain's far end for non-zero bits that betray a broken chain.
module config_loader
   import config_pkg::*;
#(
   parameter int CHAIN_BITS   = CHAIN_LEN,
   parameter int WORD_WIDTH   = 8,
   parameter int CLEAR_CYCLES = 4
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] word_data,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  cfg_nreset,
   output logic                  cfg_enable,
   output logic                  cfg_data,
   input  logic                  cfg_return,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);
   localparam int BW = $clog2(CHAIN_BITS + 1);
   localparam int KW = $clog2(CLEAR_CYCLES + 1);
   state_t        r_state;
   logic [BW-1:0] r_bit_cnt;
   logic [KW-1:0] r_clr_cnt;
   logic          r_cfg_nreset, r_cfg_enable, r_word_ready, r_busy, r_done, r_error;
   logic [BW-1:0] w_bit_nxt;
   logic          w_final, w_last, w_load, w_shift;
   assign w_bit_nxt = r_bit_cnt + 1'b1;
   assign w_final   = w_bit_nxt == BW'(CHAIN_BITS);
   assign w_load    = r_state == FETCH && word_valid && r_word_ready;
   assign w_shift   = r_state == SHIFT;
   config_serializer #(.WORD_WIDTH(WORD_WIDTH)) u_ser (
      .clock   (clock),
      .nreset  (nreset),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_clear (w_shift && w_final),
      .i_data  (word_data),
      .o_bit   (cfg_data),
      .o_last  (w_last)
   );
   always_ff @(posedge clock) begin
      if (!nreset) begin
         r_state      <= IDLE;
         r_bit_cnt    <= '0;
         r_clr_cnt    <= '0;
         r_cfg_nreset <= 1'b1;
         r_cfg_enable <= 1'b0;
         r_word_ready <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_cfg_enable && cfg_return) r_error <= 1'b1;
         case (r_state)
            IDLE: if (start) begin
               r_state      <= CLEAR;
               r_cfg_nreset <= 1'b0;
               r_busy       <= 1'b1;
               r_error      <= 1'b0;
               r_bit_cnt    <= '0;
               r_clr_cnt    <= '0;
            end
            CLEAR: if (r_clr_cnt == KW'(CLEAR_CYCLES - 1)) begin
               r_state      <= FETCH;
               r_cfg_nreset <= 1'b1;
               r_word_ready <= 1'b1;
            end else r_clr_cnt <= r_clr_cnt + 1'b1;
            FETCH: if (w_load) begin
               r_state      <= SHIFT;
               r_word_ready <= 1'b0;
               r_cfg_enable <= 1'b1;
            end
            SHIFT: begin
               r_bit_cnt <= w_bit_nxt;
               // The chain length wins over the word boundary: leftover bits are dropped.
               if (w_final) begin
                  r_state      <= DONE;
                  r_cfg_enable <= 1'b0;
                  r_done       <= 1'b1;
               end else if (w_last) begin
                  r_state      <= FETCH;
                  r_cfg_enable <= 1'b0;
                  r_word_ready <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign cfg_nreset = r_cfg_nreset;
   assign cfg_enable = r_cfg_enable;
   assign word_ready = r_word_ready;
   assign busy       = r_busy;
   assign done       = r_done;
   assign error      = r_error;
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed scenarios against a 16-bit and a 20-bit chain loader.
module tb_config_loader;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic       nreset = 1'b0, start_a = 1'b0, start_b = 1'b0, word_valid = 1'b0, cfg_return = 1'b0;
   logic [7:0] word_data = 8'h00;
   logic a_ready, a_nr, a_en, a_dat, a_busy, a_done, a_err;
   logic b_ready, b_nr, b_en, b_dat, b_busy, b_done, b_err;
   int pass_cnt = 0, chk_cnt = 0;
   int nr_cnt, nr_first, nr_last, rdy_first, rdy_cnt, done_c, en_cnt, en_win, hs, err_first;
   logic err_c1, err_done, busy_done, busy_after;
   logic [31:0] bits;
   logic [6:0]  snap;

   config_loader #(.CHAIN_BITS(16), .WORD_WIDTH(8), .CLEAR_CYCLES(4)) dut_a (
      .clock(clk), .nreset(nreset), .start(start_a), .word_data(word_data), .word_valid(word_valid),
      .word_ready(a_ready), .cfg_nreset(a_nr), .cfg_enable(a_en), .cfg_data(a_dat),
      .cfg_return(cfg_return), .busy(a_busy), .done(a_done), .error(a_err));
   config_loader #(.CHAIN_BITS(20), .WORD_WIDTH(8), .CLEAR_CYCLES(4)) dut_b (
      .clock(clk), .nreset(nreset), .start(start_b), .word_data(word_data), .word_valid(word_valid),
      .word_ready(b_ready), .cfg_nreset(b_nr), .cfg_enable(b_en), .cfg_data(b_dat),
      .cfg_return(cfg_return), .busy(b_busy), .done(b_done), .error(b_err));

   // Cycle 0 is the cycle in which start is high; outputs are sampled 1 time unit after each edge.
   task automatic run(input bit sel, input logic [7:0] w0, w1, w2, w3, input int nw,
                      input int gap, input int fault_at, input int abort_c);
      logic [7:0] wq [4];
      int idx = 0, hold = 0;
      logic rdy, nr, en, dat, bsy, dn, er;
      wq = '{w0, w1, w2, w3};
      nr_cnt = 0; nr_first = -1; nr_last = -1; rdy_first = -1; rdy_cnt = 0; done_c = -1;
      en_cnt = 0; en_win = 0; hs = 0; err_first = -1; bits = '0; snap = '1;
      err_c1 = 1'bx; err_done = 1'bx; busy_done = 1'bx; busy_after = 1'bx;
      start_a = !sel; start_b = sel;
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      for (int c = 1; c < 200; c++) begin
         rdy = sel ? b_ready : a_ready; nr = sel ? b_nr : a_nr; en = sel ? b_en : a_en;
         dat = sel ? b_dat : a_dat; bsy = sel ? b_busy : a_busy; dn = sel ? b_done : a_done;
         er = sel ? b_err : a_err;
         if (abort_c > 0 && c == abort_c + 1) begin
            snap = {rdy, nr, en, dat, bsy, dn, er};
            nreset = 1'b1;
            break;
         end
         if (!nr) begin nr_cnt++; if (nr_first < 0) nr_first = c; nr_last = c; end
         if (rdy) begin rdy_cnt++; if (rdy_first < 0) rdy_first = c; end
         if (en) begin
            if (en_cnt < 32) bits[en_cnt] = dat;
            en_cnt++;
            if (c >= 14 && c <= 23) en_win++;
         end
         cfg_return = en && (en_cnt == fault_at);
         if (er && err_first < 0) err_first = c;
         if (c == 1) err_c1 = er;
         if (dn) begin done_c = c; err_done = er; busy_done = bsy; end
         if (done_c > 0 && c == done_c + 1) begin busy_after = bsy; break; end
         word_valid = idx < nw && hold == 0;
         word_data  = idx < nw ? wq[idx & 3] : 8'h00;
         if (rdy && word_valid) begin hs++; idx++; hold = gap > 0 ? gap + 8 : 0; end
         else if (hold > 0) hold--;
         if (abort_c == c) nreset = 1'b0;
         @(posedge clk); #1;
      end
      word_valid = 1'b0; cfg_return = 1'b0;
   endtask

   task automatic test_reset;
      logic seen = 1'b0;
      nreset = 1'b0;
      repeat (3) @(posedge clk);
      #1 nreset = 1'b1;
      @(posedge clk); #1;
      chk_cnt++; if (a_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", a_ready); else pass_cnt++;
      chk_cnt++; if (a_nr !== 1'b1) $display("FAIL reset_cfg_nreset got %b want 1", a_nr); else pass_cnt++;
      chk_cnt++; if (a_en !== 1'b0) $display("FAIL reset_enable got %b want 0", a_en); else pass_cnt++;
      chk_cnt++; if (a_dat !== 1'b0) $display("FAIL reset_data got %b want 0", a_dat); else pass_cnt++;
      chk_cnt++; if (a_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", a_busy); else pass_cnt++;
      chk_cnt++; if (a_done !== 1'b0) $display("FAIL reset_done got %b want 0", a_done); else pass_cnt++;
      chk_cnt++; if (a_err !== 1'b0) $display("FAIL reset_error got %b want 0", a_err); else pass_cnt++;
      word_valid = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (a_ready !== 1'b0 || b_ready !== 1'b0) seen = 1'b1;
      end
      word_valid = 1'b0;
      chk_cnt++; if (seen !== 1'b0) $display("FAIL idle_no_ready got %b want 0", seen); else pass_cnt++;
   endtask

   task automatic test_exact;
      run(1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 2, 0, 0, 0);
      chk_cnt++; if (nr_cnt !== 4 || nr_first !== 1 || nr_last !== 4)
         $display("FAIL exact_clear got %0d cycles %0d..%0d want 4 cycles 1..4", nr_cnt, nr_first, nr_last); else pass_cnt++;
      chk_cnt++; if (rdy_first !== 5) $display("FAIL exact_first_ready got %0d want 5", rdy_first); else pass_cnt++;
      chk_cnt++; if (bits[15:0] !== 16'b0011110010100101 || en_cnt !== 16)
         $display("FAIL exact_bits got %h/%0d want 3ca5/16", bits[15:0], en_cnt); else pass_cnt++;
      chk_cnt++; if (done_c !== 23) $display("FAIL exact_done got %0d want 23", done_c); else pass_cnt++;
      chk_cnt++; if (busy_done !== 1'b1 || busy_after !== 1'b0)
         $display("FAIL exact_busy got %b%b want 10", busy_done, busy_after); else pass_cnt++;
      chk_cnt++; if (err_done !== 1'b0) $display("FAIL exact_error got %b want 0", err_done); else pass_cnt++;
   endtask

   task automatic test_partial;
      run(1'b1, 8'hFF, 8'h00, 8'hFF, 8'hAA, 4, 0, 0, 0);
      chk_cnt++; if (en_cnt !== 20) $display("FAIL partial_enables got %0d want 20", en_cnt); else pass_cnt++;
      chk_cnt++; if (bits[19:16] !== 4'hF) $display("FAIL partial_last4 got %h want f", bits[19:16]); else pass_cnt++;
      chk_cnt++; if (bits[19:0] !== 20'hF00FF) $display("FAIL partial_bits got %h want f00ff", bits[19:0]); else pass_cnt++;
      chk_cnt++; if (hs !== 3 || rdy_cnt !== 3)
         $display("FAIL partial_handshakes got %0d hs %0d ready want 3 3", hs, rdy_cnt); else pass_cnt++;
      chk_cnt++; if (done_c !== 28) $display("FAIL partial_done got %0d want 28", done_c); else pass_cnt++;
   endtask

   task automatic test_backpressure;
      run(1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 2, 10, 0, 0);
      chk_cnt++; if (en_win !== 0) $display("FAIL bp_gap_enable got %0d want 0", en_win); else pass_cnt++;
      chk_cnt++; if (bits[15:0] !== 16'b0011110010100101 || en_cnt !== 16)
         $display("FAIL bp_bits got %h/%0d want 3ca5/16", bits[15:0], en_cnt); else pass_cnt++;
      chk_cnt++; if (done_c !== 33) $display("FAIL bp_done got %0d want 33", done_c); else pass_cnt++;
   endtask

   task automatic test_fault;
      run(1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 2, 0, 5, 0);
      chk_cnt++; if (err_first !== 11) $display("FAIL fault_error_rise got %0d want 11", err_first); else pass_cnt++;
      chk_cnt++; if (err_done !== 1'b1) $display("FAIL fault_error_at_done got %b want 1", err_done); else pass_cnt++;
      chk_cnt++; if (a_err !== 1'b1) $display("FAIL fault_error_idle got %b want 1", a_err); else pass_cnt++;
      run(1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 2, 0, 0, 0);
      chk_cnt++; if (err_c1 !== 1'b0 || err_done !== 1'b0)
         $display("FAIL fault_error_cleared got %b%b want 00", err_c1, err_done); else pass_cnt++;
   endtask

   task automatic test_abort;
      run(1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 2, 0, 0, 18);
      chk_cnt++; if (snap !== 7'b0100000) $display("FAIL abort_outputs got %b want 0100000", snap); else pass_cnt++;
      run(1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 2, 0, 0, 0);
      chk_cnt++; if (done_c !== 23) $display("FAIL abort_reload_done got %0d want 23", done_c); else pass_cnt++;
      chk_cnt++; if (bits[15:0] !== 16'b0011110010100101)
         $display("FAIL abort_reload_bits got %h want 3ca5", bits[15:0]); else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_exact;
      test_partial;
      test_backpressure;
      test_fault;
      test_abort;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
